video_capture: RTL and testbench

Samples an incoming 640x480 VGA-timed pixel stream (8-bit pixel, active-low hSync/vSync) and recovers pixel and line position from the sync edges. Every second pixel on every second line is written into the 320x240 frame buffer through a request/acknowledge write port. This gives a 2x downsample, the inverse of the frame-buffer-to-VGA output path. The block sits between an external video source (or a loopback of our own VGA output) and the memory manager's write side.

---
 rtl/video_capture.sv | 151 +++++++++++++++
 tb/tb_video_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_capture.sv
// Captures a VGA-timed pixel stream into the 320x240 frame buffer at half resolution,
// recovering position from sync edges and only writing once the input timing is locked.
module video_capture #(
  parameter int H_VISIBLE    = 640,
  parameter int H_BACK_PORCH = 48,
  parameter int H_TOTAL      = 800,
  parameter int V_VISIBLE    = 480,
  parameter int V_BACK_PORCH = 33,
  parameter int V_TOTAL      = 525
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixelEnable,
  input  logic        hSyncIn,
  input  logic        vSyncIn,
  input  logic [7:0]  videoInput,
  output logic [16:0] writeAddress,
  output logic [7:0]  writeData,
  output logic        writeRequest,
  input  logic        writeAck,
  output logic        locked,
  output logic        frameStart,
  output logic        overflow
);
  typedef enum logic [1:0] {ACQUIRE, VERIFY, LOCKED} LockState;

  localparam logic [9:0]  COUNT_MAX = 10'h3FF;
  localparam logic [9:0]  H_START   = 10'(H_BACK_PORCH);
  localparam logic [9:0]  H_END     = 10'(H_BACK_PORCH + H_VISIBLE);
  localparam logic [9:0]  V_START   = 10'(V_BACK_PORCH);
  localparam logic [9:0]  V_END     = 10'(V_BACK_PORCH + V_VISIBLE);
  localparam logic [10:0] H_LINE    = 11'(H_TOTAL);
  localparam logic [9:0]  V_FRAME   = 10'(V_TOTAL);

  LockState   state;
  logic       prevH, prevV;
  logic [9:0] pixelCount, lineCount;
  logic [1:0] goodCount;
  logic       lineArmed, badLineSeen;

  logic       hRise, vRise;
  logic [9:0] pixelNext, lineNext;
  logic [9:0] xRel;
  logic [8:0] yRel;
  logic       visible, lineBad, frameGood, capture;

  assign hRise = pixelEnable & hSyncIn & ~prevH;
  assign vRise = pixelEnable & vSyncIn & ~prevV;

  // Position of the current sample: the sample carrying a sync rise is position 0.
  always_comb begin
    pixelNext = pixelCount;
    lineNext  = lineCount;
    if (hRise)
      pixelNext = '0;
    else if (pixelCount != COUNT_MAX)
      pixelNext = pixelCount + 10'd1;
    if (vRise)
      lineNext = '0;
    else if (hRise && lineCount != COUNT_MAX)
      lineNext = lineCount + 10'd1;
  end

  assign xRel      = pixelNext - H_START;
  assign yRel      = 9'(lineNext - V_START);
  assign visible   = (pixelNext >= H_START) && (pixelNext < H_END) &&
                     (lineNext >= V_START) && (lineNext < V_END);
  assign lineBad   = hRise & lineArmed & (({1'b0, pixelCount} + 11'd1) != H_LINE);
  assign frameGood = (lineCount == V_FRAME) & ~badLineSeen & ~lineBad;
  assign capture   = pixelEnable & visible & locked & ~xRel[0] & ~yRel[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      prevH      <= 1'b1;
      prevV      <= 1'b1;
      pixelCount <= '0;
      lineCount  <= '0;
      lineArmed  <= 1'b0;
    end else if (pixelEnable) begin
      prevH      <= hSyncIn;
      prevV      <= vSyncIn;
      pixelCount <= pixelNext;
      lineCount  <= lineNext;
      if (hRise)
        lineArmed <= 1'b1;
    end
  end

  // The first vSync rise after acquisition only aligns us; later rises are measured.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ACQUIRE;
      goodCount   <= '0;
      badLineSeen <= 1'b0;
      locked      <= 1'b0;
      frameStart  <= 1'b0;
    end else begin
      frameStart <= vRise;
      if (vRise)
        badLineSeen <= 1'b0;
      else if (lineBad)
        badLineSeen <= 1'b1;
      case (state)
        ACQUIRE: begin
          goodCount <= '0;
          if (vRise)
            state <= VERIFY;
        end
        VERIFY: begin
          if (vRise) begin
            if (!frameGood)
              goodCount <= '0;
            else if (goodCount == 2'd1) begin
              goodCount <= 2'd2;
              state     <= LOCKED;
              locked    <= 1'b1;
            end else
              goodCount <= goodCount + 2'd1;
          end else if (lineBad)
            goodCount <= '0;
        end
        LOCKED: begin
          if (lineBad || (vRise && !frameGood)) begin
            state     <= VERIFY;
            goodCount <= '0;
            locked    <= 1'b0;
          end
        end
        default: state <= ACQUIRE;
      endcase
    end
  end

  // A capture can reuse the buffer in the same cycle the memory accepts its contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      writeAddress <= '0;
      writeData    <= '0;
      writeRequest <= 1'b0;
      overflow     <= 1'b0;
    end else if (capture) begin
      if (!writeRequest || writeAck) begin
        writeAddress <= {yRel[8:1], xRel[9:1]};
        writeData    <= videoInput;
        writeRequest <= 1'b1;
      end else
        overflow <= 1'b1;
    end else if (writeAck)
      writeRequest <= 1'b0;
  end
endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture on a shrunken raster (20x10) so many frames fit in a short run;
// expected frame-buffer writes are queued from the generated raster and compared as they are accepted.
module tb_video_capture;
  localparam int HV = 12, HBP = 3, HT = 20, HS = 4;
  localparam int VV = 6, VBP = 2, VT = 10;

  logic        clock = 1'b0;
  logic        reset, pixelEnable, hSyncIn, vSyncIn, writeAck;
  logic [7:0]  videoInput;
  logic [16:0] writeAddress;
  logic [7:0]  writeData;
  logic        writeRequest, locked, frameStart, overflow;

  int          checks = 0, errors = 0;
  logic [24:0] expQ[$];
  bit          sbEnable = 1'b0, pushEnable = 1'b0, halfRate = 1'b1;
  bit          expLock = 1'b0, ovfProbe = 1'b0, simulProbe = 1'b0, resetProbe = 1'b0;
  int          ackDelay = 0, ackWait = 0, writesSeen = 0;
  logic [24:0] firstWrite = '0, lastWrite = '0;

  video_capture #(
    .H_VISIBLE(HV), .H_BACK_PORCH(HBP), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_BACK_PORCH(VBP), .V_TOTAL(VT)
  ) dut (
    .clock(clock), .reset(reset), .pixelEnable(pixelEnable),
    .hSyncIn(hSyncIn), .vSyncIn(vSyncIn), .videoInput(videoInput),
    .writeAddress(writeAddress), .writeData(writeData), .writeRequest(writeRequest),
    .writeAck(writeAck), .locked(locked), .frameStart(frameStart), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic h, input logic v, input logic [7:0] pix);
    hSyncIn     = h;
    vSyncIn     = v;
    videoInput  = pix;
    pixelEnable = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Addr"}, 32'(writeAddress), 32'd0);
    checkOutput({tag, "Data"}, 32'(writeData), 32'd0);
    checkOutput({tag, "Req"}, 32'(writeRequest), 32'd0);
    checkOutput({tag, "Locked"}, 32'(locked), 32'd0);
    checkOutput({tag, "FrameStart"}, 32'(frameStart), 32'd0);
    checkOutput({tag, "Overflow"}, 32'(overflow), 32'd0);
  endtask

  // Lines are numbered 1..VT; the vSync rise lands in line VT at the start of its sync pulse.
  task automatic sendFrame(input int shortLine, input bit dropVsync);
    for (int ln = 1; ln <= VT; ln++) begin
      for (int p = 0; p < HT; p++) begin
        logic       h, v;
        logic [7:0] pix;
        bit         vis, vRisePt;
        int         x, y;
        if (ln == shortLine && p == HT - HS - 1) continue;
        h       = !(p >= HT - HS);
        v       = dropVsync || !((ln == VT - 1 && p >= HT - HS) || (ln == VT && p < HT - HS));
        vRisePt = !dropVsync && ln == VT && p == HT - HS;
        x       = p - HBP;
        y       = ln - VBP;
        vis     = (x >= 0) && (x < HV) && (y >= 0) && (y < VV);
        pix     = 8'(x) ^ 8'(y);
        if (pushEnable && vis && (x % 2 == 0) && (y % 2 == 0))
          expQ.push_back({17'((y / 2) * 512 + x / 2), pix});
        applyStimulus(h, v, pix);
        if (vRisePt) begin
          checkOutput("frameStartOnVsync", 32'(frameStart), 32'd1);
          checkOutput("lockedAtVsync", 32'(locked), 32'(expLock));
        end
        if (shortLine != 0 && ln == shortLine + 1 && p == 0)
          checkOutput("lockedAfterBadLine", 32'(locked), 32'd0);
        if (ovfProbe && vis && y == 0 && x == 0)
          checkOutput("overflowBeforeDrop", 32'(overflow), 32'd0);
        if (ovfProbe && vis && y == 0 && x == 2)
          checkOutput("overflowOnDrop", 32'(overflow), 32'd1);
        if (simulProbe && vis && y == 0 && x == 2) begin
          checkOutput("simulReqHeld", 32'(writeRequest), 32'd1);
          checkOutput("simulAddrAdvance", 32'(writeAddress), 32'd1);
          checkOutput("simulData", 32'(writeData), 32'(pix));
        end
        if (resetProbe && vis && y == 0 && x == 3) begin
          checkOutput("pendingBeforeReset", 32'(writeRequest), 32'd1);
          pixelEnable = 1'b0;
          reset       = 1'b1;
          @(posedge clock); #1;
          reset = 1'b0;
          checkAllZero("midReset");
        end
        if (halfRate) begin
          pixelEnable = 1'b0;
          @(posedge clock); #1;
          if (vRisePt)
            checkOutput("frameStartPulse", 32'(frameStart), 32'd0);
        end
      end
    end
  endtask

  task automatic scoredFrame();
    writesSeen = 0;
    sbEnable   = 1'b1;
    pushEnable = 1'b1;
    sendFrame(0, 1'b0);
    pushEnable = 1'b0;
    sbEnable   = 1'b0;
    checkOutput("writeCount", 32'(writesSeen), 32'((VV / 2) * (HV / 2)));
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  // Memory-side responder: acknowledges after ackDelay cycles of a pending request (0 = always ready).
  initial begin
    writeAck = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (ackDelay == 0)
        writeAck = 1'b1;
      else begin
        if (writeAck) begin
          writeAck = 1'b0;
          ackWait  = 0;
        end
        if (writeRequest) begin
          ackWait++;
          if (ackWait >= ackDelay)
            writeAck = 1'b1;
        end else
          ackWait = 0;
      end
    end
  end

  // Scoreboard: a write is accepted at the next rising edge when request and ack are both high.
  initial begin
    forever begin
      @(negedge clock);
      if (sbEnable && writeRequest && writeAck) begin
        if (writesSeen == 0)
          firstWrite = {writeAddress, writeData};
        lastWrite = {writeAddress, writeData};
        writesSeen++;
        checkOutput("writeExpected", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0)
          checkOutput("writeAddrData", 32'({writeAddress, writeData}), 32'(expQ.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (observed running, required finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    pixelEnable = 1'b0;
    hSyncIn     = 1'b1;
    vSyncIn     = 1'b1;
    videoInput  = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    $display("[TB] acquisition and lock");
    expLock = 1'b0;
    sendFrame(0, 1'b0);
    sendFrame(0, 1'b0);
    expLock = 1'b1;
    sendFrame(0, 1'b0);
    checkOutput("lockedAfterThirdVsync", 32'(locked), 32'd1);

    $display("[TB] full frame with writeAck tied high");
    scoredFrame();
    checkOutput("firstWrite", 32'(firstWrite), 32'({17'd0, 8'd0}));
    checkOutput("lastWrite", 32'(lastWrite),
                32'({17'(((VV - 2) / 2) * 512 + (HV - 2) / 2), 8'((HV - 2) ^ (VV - 2))}));

    $display("[TB] backpressure and simultaneous ack");
    ackDelay = 3;
    scoredFrame();
    checkOutput("noOverflowDelay3", 32'(overflow), 32'd0);
    ackDelay   = 4;
    simulProbe = 1'b1;
    scoredFrame();
    simulProbe = 1'b0;
    checkOutput("noOverflowDelay4", 32'(overflow), 32'd0);

    $display("[TB] overflow with slow memory");
    ackDelay = 5;
    ovfProbe = 1'b1;
    sendFrame(0, 1'b0);
    ovfProbe = 1'b0;
    checkOutput("overflowSet", 32'(overflow), 32'd1);
    ackDelay = 0;
    scoredFrame();
    checkOutput("overflowSticky", 32'(overflow), 32'd1);

    $display("[TB] short line and relock");
    expLock = 1'b0;
    sendFrame(3, 1'b0);
    sendFrame(0, 1'b0);
    expLock = 1'b1;
    sendFrame(0, 1'b0);
    checkOutput("relocked", 32'(locked), 32'd1);

    $display("[TB] missing vSync");
    halfRate = 1'b0;
    repeat (103) sendFrame(0, 1'b1);
    checkOutput("lineCountSaturated", 32'(dut.lineCount), 32'h3FF);
    checkOutput("lockedHeldNoVsync", 32'(locked), 32'd1);
    halfRate = 1'b1;
    expLock  = 1'b0;
    sendFrame(0, 1'b0);
    checkOutput("unlockedAfterMissingVsync", 32'(locked), 32'd0);

    $display("[TB] reset mid-stream with a pending write");
    sendFrame(0, 1'b0);
    expLock = 1'b1;
    sendFrame(0, 1'b0);
    ackDelay   = 1000;
    resetProbe = 1'b1;
    expLock    = 1'b0;
    sendFrame(0, 1'b0);
    resetProbe = 1'b0;
    checkOutput("lockedAfterResetFrame", 32'(locked), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
